// File: rtl/rf_pkg.sv
// Shared defaults and reset-value helper for the parametrised register file.
package rf_pkg;

    localparam int unsigned RF_DATA_W  = 32;
    localparam int unsigned RF_ADDR_W  = 5;
    localparam int unsigned INIT_ZERO  = 0;
    localparam int unsigned INIT_INDEX = 1;

    // Reset value of register idx in 32-bit arithmetic; callers truncate to their width.
    function automatic logic [31:0] rf_init_value(input int unsigned idx, input int unsigned mode);
        return (mode == INIT_INDEX) ? 32'(idx + 32'd1) : 32'd0;
    endfunction

endpackage

// File: rtl/param_reg_file_if.sv
// Read/write bus of the register file: decode/write-back side is master, the file is slave.
interface param_reg_file_if
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W = RF_DATA_W,
    parameter int unsigned ADDR_W = RF_ADDR_W,
    parameter int unsigned NUM_RD = 2
);
    logic [NUM_RD-1:0]        Read_En;
    logic [NUM_RD*ADDR_W-1:0] Read_Addr;
    logic [NUM_RD*DATA_W-1:0] Read_Data;
    logic [1:0]               Wr_En;
    logic [ADDR_W-1:0]        Wr_Addr0;
    logic [DATA_W-1:0]        Wr_Data0;
    logic [ADDR_W-1:0]        Wr_Addr1;
    logic [DATA_W-1:0]        Wr_Data1;

    modport master (
        output Read_En, Read_Addr, Wr_En, Wr_Addr0, Wr_Data0, Wr_Addr1, Wr_Data1,
        input  Read_Data
    );

    modport slave (
        input  Read_En, Read_Addr, Wr_En, Wr_Addr0, Wr_Data0, Wr_Addr1, Wr_Data1,
        output Read_Data
    );
endinterface

// File: rtl/rf_read_port.sv
// One registered read port with write-first bypass against both write ports.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] rf_data_i,
    input  logic [1:0]        wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr0_i,
    input  logic [DATA_W-1:0] wr_data0_i,
    input  logic [ADDR_W-1:0] wr_addr1_i,
    input  logic [DATA_W-1:0] wr_data1_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] rd_data_q;

    // Zero register beats any bypass; port 1 beats port 0 when both hit.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en_i) begin
            if ((ZERO_REG != 0) && (rd_addr_i == '0)) begin
                rd_data_d = '0;
            end else if (wr_en_i[1] && (wr_addr1_i == rd_addr_i)) begin
                rd_data_d = wr_data1_i;
            end else if (wr_en_i[0] && (wr_addr0_i == rd_addr_i)) begin
                rd_data_d = wr_data0_i;
            end else begin
                rd_data_d = rf_data_i;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/param_reg_file.sv
// Parametrised register file: two prioritised write ports, NUM_RD registered bypassing read ports.
module param_reg_file
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W    = RF_DATA_W,
    parameter int unsigned ADDR_W    = RF_ADDR_W,
    parameter int unsigned NUM_RD    = 2,
    parameter int unsigned ZERO_REG  = 1,
    parameter int unsigned INIT_MODE = INIT_INDEX
) (
    input  logic            Clk,
    input  logic            Reset,
    param_reg_file_if.slave bus
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_W;

    logic [DATA_W-1:0]        regs_q [DEPTH];
    logic [DATA_W-1:0]        regs_d [DEPTH];
    logic [DATA_W-1:0]        rd_data [NUM_RD];
    logic [NUM_RD*DATA_W-1:0] rd_flat;

    function automatic logic wr_allowed(input logic [ADDR_W-1:0] addr);
        return !((ZERO_REG != 0) && (addr == '0));
    endfunction

    // Port 1 applied last so it overrides port 0 on an address collision.
    always_comb begin
        regs_d = regs_q;
        if (bus.Wr_En[0] && wr_allowed(bus.Wr_Addr0)) begin
            regs_d[bus.Wr_Addr0] = bus.Wr_Data0;
        end
        if (bus.Wr_En[1] && wr_allowed(bus.Wr_Addr1)) begin
            regs_d[bus.Wr_Addr1] = bus.Wr_Data1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= ((ZERO_REG != 0) && (i == 0)) ? '0
                                                           : DATA_W'(rf_init_value(i, INIT_MODE));
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        assign addr = bus.Read_Addr[k*ADDR_W +: ADDR_W];

        rf_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .Clk        (Clk),
            .Reset      (Reset),
            .rd_en_i    (bus.Read_En[k]),
            .rd_addr_i  (addr),
            .rf_data_i  (regs_q[addr]),
            .wr_en_i    (bus.Wr_En),
            .wr_addr0_i (bus.Wr_Addr0),
            .wr_data0_i (bus.Wr_Data0),
            .wr_addr1_i (bus.Wr_Addr1),
            .wr_data1_i (bus.Wr_Data1),
            .rd_data_o  (rd_data[k])
        );
    end

    always_comb begin
        rd_flat = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            rd_flat[k*DATA_W +: DATA_W] = rd_data[k];
        end
    end

    assign bus.Read_Data = rd_flat;

endmodule

// File: tb/tb_param_reg_file.sv
// Directed bench: a ZERO_REG=1 and a ZERO_REG=0 file driven in lockstep against an array model.
module tb_param_reg_file;
    import rf_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 3;
    localparam int unsigned NREG = 32;

    logic Clk = 1'b0;
    logic Reset = 1'b1;

    logic [NR-1:0]         ren;
    logic [NR-1:0][AW-1:0] ra;
    logic [1:0]            wen;
    logic [AW-1:0]         wa0, wa1;
    logic [DW-1:0]         wd0, wd1;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // mem/expd index 0 = ZERO_REG build, 1 = plain build
    logic [DW-1:0] mem  [2][NREG];
    logic [DW-1:0] expd [2][NR];

    param_reg_file_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) if_z ();
    param_reg_file_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) if_n ();

    assign if_z.Read_En = ren;   assign if_n.Read_En = ren;
    assign if_z.Read_Addr = ra;  assign if_n.Read_Addr = ra;
    assign if_z.Wr_En = wen;     assign if_n.Wr_En = wen;
    assign if_z.Wr_Addr0 = wa0;  assign if_n.Wr_Addr0 = wa0;
    assign if_z.Wr_Data0 = wd0;  assign if_n.Wr_Data0 = wd0;
    assign if_z.Wr_Addr1 = wa1;  assign if_n.Wr_Addr1 = wa1;
    assign if_z.Wr_Data1 = wd1;  assign if_n.Wr_Data1 = wd1;

    param_reg_file #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .INIT_MODE(INIT_INDEX))
        dut_z (.Clk(Clk), .Reset(Reset), .bus(if_z.slave));
    param_reg_file #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0), .INIT_MODE(INIT_INDEX))
        dut_n (.Clk(Clk), .Reset(Reset), .bus(if_n.slave));

    always #5 Clk = ~Clk;

    function automatic logic [DW-1:0] rd(input int d, input int k);
        return (d == 0) ? if_z.Read_Data[k*DW +: DW] : if_n.Read_Data[k*DW +: DW];
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NREG; i++) mem[d][i] = (d == 0 && i == 0) ? 32'd0 : 32'(i + 1);
            for (int k = 0; k < NR; k++) expd[d][k] = '0;
        end
    endtask

    // Commit the edge's writes to the array, then every enabled port samples the new contents.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (wen[0] && !(d == 0 && wa0 == 0)) mem[d][wa0] = wd0;
            if (wen[1] && !(d == 0 && wa1 == 0)) mem[d][wa1] = wd1;
            for (int k = 0; k < NR; k++)
                if (ren[k]) expd[d][k] = (d == 0 && ra[k] == 0) ? 32'd0 : mem[d][ra[k]];
        end
    endtask

    task automatic cycle();
        @(posedge Clk);
        if (!Reset) model_edge();
        @(negedge Clk);
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++)
                for (int k = 0; k < NR; k++)
                    check($sformatf("model d%0d p%0d", d, k), rd(d, k), expd[d][k]);
        end
    end

    initial begin
        ren = '0; ra = '0; wen = '0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
        model_reset();
        chk_en = 1'b1;
        @(negedge Clk);
        check("reset z p0", rd(0, 0), 32'd0);
        check("reset n p2", rd(1, 2), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;

        ren = 3'b111; ra[0] = 5'd0; ra[1] = 5'd5; ra[2] = 5'd31;
        cycle();
        check("init z a0", rd(0, 0), 32'd0);
        check("init z a5", rd(0, 1), 32'd6);
        check("init z a31", rd(0, 2), 32'd32);
        check("init n a0", rd(1, 0), 32'd1);

        wen = 2'b01; wa0 = 5'd3; wd0 = 32'hDEADBEEF; ra[0] = 5'd3;
        cycle();
        check("bypass p0", rd(0, 0), 32'hDEADBEEF);

        wen = 2'b11; wa0 = 5'd7; wd0 = 32'h11; wa1 = 5'd7; wd1 = 32'h22; ra[0] = 5'd7;
        cycle();
        check("prio bypass", rd(0, 0), 32'h22);
        wen = 2'b00;
        cycle();
        check("prio stored", rd(0, 0), 32'h22);

        wen = 2'b01; wa0 = 5'd0; wd0 = 32'hFFFFFFFF; ra[0] = 5'd0;
        cycle();
        check("zero bypass z", rd(0, 0), 32'd0);
        check("zero bypass n", rd(1, 0), 32'hFFFFFFFF);
        wen = 2'b10; wa1 = 5'd0; wd1 = 32'h5A5A;
        cycle();
        check("zero p1 z", rd(0, 0), 32'd0);
        wen = 2'b00;
        cycle();
        check("zero stored n", rd(1, 0), 32'h5A5A);

        ra[1] = 5'd4;
        cycle();
        check("pre hold", rd(0, 1), 32'd5);
        ren[1] = 1'b0; ra[1] = 5'd9;
        cycle();
        check("hold p1", rd(0, 1), 32'd5);
        ren[1] = 1'b1;
        cycle();
        check("reenable p1", rd(0, 1), 32'd10);

        wen = 2'b11; wa0 = 5'd20; wd0 = 32'h100; wa1 = 5'd21; wd1 = 32'h200;
        ra[0] = 5'd20; ra[1] = 5'd21; ra[2] = 5'd20;
        cycle();
        check("dual w p1", rd(0, 1), 32'h200);
        check("dual w p2", rd(0, 2), 32'h100);

        wen = 2'b01; wa0 = 5'd12; wd0 = 32'hABCD; ra[0] = 5'd12;
        cycle();
        check("pre reset", rd(0, 0), 32'hABCD);
        #2 Reset = 1'b1;
        model_reset();
        #1;
        check("async rst z", rd(0, 0), 32'd0);
        check("async rst n", rd(1, 1), 32'd0);
        wen = 2'b01; wa0 = 5'd12; wd0 = 32'h55;
        cycle();
        Reset = 1'b0;
        wen = 2'b00; ra[0] = 5'd12;
        cycle();
        check("post reset a12", rd(0, 0), 32'd13);

        for (int i = 0; i < 16; i++) begin
            wen = 2'(i % 4);
            wa0 = 5'((i * 5) % 32); wd0 = 32'h1000 + 32'(i);
            wa1 = 5'((i * 3) % 32); wd1 = 32'h2000 + 32'(i);
            ren = 3'(i) | 3'b001;
            for (int k = 0; k < NR; k++) ra[k] = 5'((i * 5 + k) % 32);
            cycle();
        end
        wen = 2'b00; ren = 3'b111;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < NR; k++) ra[k] = 5'((i * 4 + k * 11) % 32);
            cycle();
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
